// File: rtl/stream_mux_pkg.sv
// Shared types and constants for the arbitrated stream multiplexer.
package stream_mux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } smux_state_t;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational request arbiter: circular search from ptr (round-robin) or
// lowest-index-wins (fixed priority). Returns one-hot grant plus its index.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int N_CH  = 8,
  parameter  int MODE  = MODE_RR,
  localparam int IDX_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_CH-1:0]  grant,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    int   start;
    int   j;
    logic found;
    // NOTE: every variable gets a default first so no path can infer a latch.
    grant = '0;
    idx   = '0;
    found = 1'b0;
    start = (MODE == MODE_FIXED) ? 0 : int'(ptr);
    j     = 0;
    for (int k = 0; k < N_CH; k++) begin
      j = start + k;
      if (j >= N_CH) j = j - N_CH;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/stream_arb_mux.sv
// Registered N-to-1 stream multiplexer: arbitrates between channels and
// forwards whole packets atomically through a single output register.
module stream_arb_mux
  import stream_mux_pkg::*;
#(
  parameter  int N_CH  = 8,
  parameter  int WIDTH = 8,
  parameter  int MODE  = MODE_RR,
  localparam int IDX_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_last,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_last,
  output logic [IDX_W-1:0]      out_sel,
  input  logic                  out_ready
);

  smux_state_t      state, state_next;
  logic [IDX_W-1:0] g, ptr, sel, win_idx;
  logic [N_CH-1:0]  win_grant;
  logic             can_load, transfer;
  logic [WIDTH-1:0] ch_data [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_unpack
    assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  rr_arbiter #(.N_CH(N_CH), .MODE(MODE)) u_arb (
    .req   (in_valid),
    .ptr   (ptr),
    .grant (win_grant),
    .idx   (win_idx)
  );

  // Inside a packet the lock overrides the arbiter, so in BUSY the granted
  // channel keeps its ready even while its own valid is low.
  assign sel      = (state == BUSY) ? g : win_idx;
  assign can_load = !out_valid || out_ready;
  assign transfer = in_valid[sel] && in_ready[sel];

  always_comb begin
    in_ready = '0;
    if (!rst && can_load && (state == BUSY || |win_grant)) in_ready[sel] = 1'b1;
  end

  always_comb begin
    state_next = state;
    if (transfer) state_next = in_last[sel] ? IDLE : BUSY;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      g         <= '0;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else begin
      state <= state_next;
      if (transfer) begin
        out_valid <= 1'b1;
        out_data  <= ch_data[sel];
        out_last  <= in_last[sel];
        out_sel   <= sel;
        if (in_last[sel]) ptr <= (sel == IDX_W'(N_CH - 1)) ? '0 : sel + 1'b1;
        else              g   <= sel;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_arb_mux.sv
// Scoreboard bench for stream_arb_mux: per-channel sources feed the DUT and
// expected output beats are queued in the order arbitration must produce them.
module tb_stream_arb_mux;
  import stream_mux_pkg::*;

  localparam int N_CH  = 8;
  localparam int WIDTH = 8;

  logic                  clk;
  logic                  rst;
  logic [N_CH-1:0]       in_valid;
  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_last;
  logic [N_CH-1:0]       in_ready, fx_in_ready;
  logic                  out_valid, fx_out_valid;
  logic [WIDTH-1:0]      out_data, fx_out_data;
  logic                  out_last, fx_out_last;
  logic [2:0]            out_sel, fx_out_sel;
  logic                  out_ready;

  stream_arb_mux #(.N_CH(N_CH), .WIDTH(WIDTH), .MODE(MODE_RR)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_sel(out_sel), .out_ready(out_ready)
  );

  stream_arb_mux #(.N_CH(N_CH), .WIDTH(WIDTH), .MODE(MODE_FIXED)) dut_fx (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(fx_in_ready), .out_valid(fx_out_valid), .out_data(fx_out_data),
    .out_last(fx_out_last), .out_sel(fx_out_sel), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t           exp_q[$];
  logic [8:0]      src_mem [N_CH][16];
  int              src_head [N_CH];
  int              src_tail [N_CH];
  logic [N_CH-1:0] hold_mask;
  int              n_checks;
  int              n_pass;
  int              pops;

  logic [N_CH-1:0] rdy_s, fx_rdy_s;
  logic            samp_valid, fx_samp_valid, fx_samp_last;
  logic [7:0]      samp_data, fx_samp_data;
  logic [2:0]      samp_sel, fx_samp_sel;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  task automatic add_src(input int ch, input logic [7:0] data, input logic last);
    src_mem[ch][src_tail[ch]] = {last, data};
    src_tail[ch]++;
  endtask

  task automatic add_exp(input logic [2:0] sel, input logic [7:0] data, input logic last);
    beat_t b;
    b.sel  = sel;
    b.data = data;
    b.last = last;
    exp_q.push_back(b);
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N_CH; i++) begin
      if (src_head[i] < src_tail[i] && !hold_mask[i]) begin
        in_valid[i]          = 1'b1;
        in_data[i*WIDTH +: WIDTH] = src_mem[i][src_head[i]][7:0];
        in_last[i]           = src_mem[i][src_head[i]][8];
      end else begin
        in_valid[i]          = 1'b0;
        in_data[i*WIDTH +: WIDTH] = '0;
        in_last[i]           = 1'b0;
      end
    end
  endtask

  function automatic logic busy();
    for (int i = 0; i < N_CH; i++) if (src_head[i] < src_tail[i]) return 1'b1;
    return exp_q.size() != 0;
  endfunction

  // One clock: sample at negedge, score the output beat, advance sources that
  // handshook, then redrive inputs just after the rising edge.
  task automatic step();
    logic [N_CH-1:0] acc;
    beat_t           e;
    @(negedge clk);
    rdy_s         = in_ready;
    fx_rdy_s      = fx_in_ready;
    samp_valid    = out_valid;
    samp_data     = out_data;
    samp_sel      = out_sel;
    fx_samp_valid = fx_out_valid;
    fx_samp_data  = fx_out_data;
    fx_samp_sel   = fx_out_sel;
    fx_samp_last  = fx_out_last;
    check("ready_onehot", 32'($countones(in_ready) <= 1), 32'd1);
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("beat_extra", {21'd0, out_sel, out_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("beat_sel", 32'(out_sel), 32'(e.sel));
        check("beat_data", 32'(out_data), 32'(e.data));
        check("beat_last", 32'(out_last), 32'(e.last));
        pops++;
      end
    end
    acc = in_valid & in_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N_CH; i++) if (acc[i]) src_head[i]++;
    drive_inputs();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (busy() && n < 60) begin
      step();
      n++;
    end
    check(tag, 32'(busy()), 32'd0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    for (int i = 0; i < N_CH; i++) src_head[i] = src_tail[i];
    exp_q.delete();
    hold_mask = '0;
    drive_inputs();
    step();
    rst = 1'b0;
    drive_inputs();
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    pops      = 0;
    hold_mask = '0;
    out_ready = 1'b1;
    in_data   = '0;
    in_last   = '0;
    for (int i = 0; i < N_CH; i++) begin
      src_head[i] = 0;
      src_tail[i] = 0;
    end

    // Reset with every channel requesting
    rst      = 1'b1;
    in_valid = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_sel", 32'(out_sel), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Sweep: one beat per channel, back to back
    for (int i = 0; i < N_CH; i++) begin
      add_src(i, 8'hA0 + 8'(i), 1'b1);
      add_exp(3'(i), 8'hA0 + 8'(i), 1'b1);
    end
    drive_inputs();
    pops = 0;
    repeat (9) step();
    check("sweep_pops", 32'(pops), 32'd8);
    drain("sweep_drain");

    // Packet lock: ch2 4 beats with a source stall, ch5 waiting
    for (int b = 0; b < 4; b++) begin
      add_src(2, 8'h20 + 8'(b), b == 3);
      add_exp(3'd2, 8'h20 + 8'(b), b == 3);
    end
    add_src(5, 8'h55, 1'b1);
    add_exp(3'd5, 8'h55, 1'b1);
    drive_inputs();
    repeat (2) begin
      step();
      check("lock_rdy5", 32'(rdy_s[5]), 32'd0);
    end
    hold_mask[2] = 1'b1;
    drive_inputs();
    repeat (2) begin
      step();
      check("stall_ready", 32'(rdy_s), 32'h04);
    end
    hold_mask[2] = 1'b0;
    drive_inputs();
    repeat (2) begin
      step();
      check("lock_rdy5", 32'(rdy_s[5]), 32'd0);
    end
    step();
    check("ch5_after_last", 32'(rdy_s), 32'h20);
    drain("lock_drain");

    // Backpressure: ptr sits at 6, so ch0..ch3 go out in index order
    for (int i = 0; i < 4; i++) begin
      add_src(i, 8'hB0 + 8'(i), 1'b1);
      add_exp(3'(i), 8'hB0 + 8'(i), 1'b1);
    end
    drive_inputs();
    step();
    out_ready = 1'b0;
    repeat (4) begin
      step();
      check("bp_valid", 32'(samp_valid), 32'd1);
      check("bp_data", 32'(samp_data), 32'hB0);
      check("bp_sel", 32'(samp_sel), 32'd0);
      check("bp_in_ready", 32'(rdy_s), 32'd0);
    end
    out_ready = 1'b1;
    drain("bp_drain");

    // Wrap vs fixed priority: ch6 last sent, then ch1 and ch7 together
    apply_reset();
    add_src(6, 8'h66, 1'b1);
    add_exp(3'd6, 8'h66, 1'b1);
    drive_inputs();
    drain("wrap_pre_drain");
    add_src(1, 8'h11, 1'b1);
    add_src(7, 8'h77, 1'b1);
    add_exp(3'd7, 8'h77, 1'b1);
    add_exp(3'd1, 8'h11, 1'b1);
    drive_inputs();
    step();
    check("rr_wrap_grant", 32'(rdy_s), 32'h80);
    check("fixed_grant", 32'(fx_rdy_s), 32'h02);
    step();
    check("fixed_out_valid", 32'(fx_samp_valid), 32'd1);
    check("fixed_out_sel", 32'(fx_samp_sel), 32'd1);
    check("fixed_out_data", 32'(fx_samp_data), 32'h11);
    check("fixed_out_last", 32'(fx_samp_last), 32'd1);
    drain("wrap_drain");

    // Reset in the middle of a ch3 packet; beat 2 is in flight and dropped
    add_src(3, 8'h30, 1'b0);
    add_src(3, 8'h31, 1'b0);
    add_src(3, 8'h32, 1'b1);
    add_exp(3'd3, 8'h30, 1'b0);
    drive_inputs();
    repeat (2) step();
    rst = 1'b1;
    src_head[3] = src_tail[3];
    drive_inputs();
    step();
    rst = 1'b0;
    step();
    check("midrst_out_valid", 32'(samp_valid), 32'd0);
    check("midrst_state", 32'(dut.state), 32'(IDLE));
    check("midrst_pending", 32'(exp_q.size()), 32'd0);
    add_src(0, 8'h5C, 1'b1);
    add_exp(3'd0, 8'h5C, 1'b1);
    drive_inputs();
    drain("midrst_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
